// File: rtl/split_struct_pkg.sv
// Shared definitions for the split struct packer.
// Holds the beat mode encodings and a generic field-order reversal helper.
package split_struct_pkg;

    localparam logic MODE_NATURAL  = 1'b0;
    localparam logic MODE_REVERSED = 1'b1;

    // Widest beat the reversal helper can handle, and the bit-index width that goes with it.
    localparam int unsigned MAX_BITS = 1024;
    localparam int unsigned IDX_W    = 10;

    // Output field k takes input field num_fields-1-k; bits above num_fields*field_w are zero.
    function automatic logic [MAX_BITS-1:0] reverse_fields(
        input logic [MAX_BITS-1:0] data,
        input int unsigned         num_fields,
        input int unsigned         field_w
    );
        logic [MAX_BITS-1:0] res;
        res = '0;
        for (int unsigned k = 0; k < num_fields; k++) begin
            for (int unsigned b = 0; b < field_w; b++) begin
                res[IDX_W'(k * field_w + b)] = data[IDX_W'((num_fields - 1 - k) * field_w + b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/split_struct_fifo.sv
// Parametrised FIFO for packed beats.
// Ports: clk, rst_n (async active-low); push_valid/push_ready/push_data on the write side;
// pop_valid/pop_ready/pop_data on the read side; count = beats currently stored.
// All outputs are registers: pop_data is a head register so it keeps the last popped
// value when the FIFO runs empty.
module split_struct_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [DATA_W-1:0]          pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [DATA_W-1:0] head_q, head_nxt;
    logic              ready_q, valid_q;
    logic              push, pop;

    assign push = push_valid && ready_q;
    assign pop  = valid_q && pop_ready;

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // New head: next stored entry after a pop, or the incoming beat when it lands at the head.
    always_comb begin
        head_nxt = head_q;
        if (pop) begin
            if (count_q > CNT_W'(1)) begin
                head_nxt = mem[rd_ptr_q + PTR_W'(1)];
            end else if (push) begin
                head_nxt = push_data;
            end
        end else if (push && (count_q == '0)) begin
            head_nxt = push_data;
        end
    end

    // Control state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_nxt;
            head_q  <= head_nxt;
            ready_q <= (count_nxt != CNT_W'(DEPTH));
            valid_q <= (count_nxt != '0);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign push_ready = ready_q;
    assign pop_valid  = valid_q;
    assign pop_data   = head_q;
    assign count      = count_q;

endmodule

// File: rtl/split_struct_packer.sv
// Packs each input beat in natural or reversed field order and buffers the result.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_fields/in_mode input beat;
// out_valid/out_ready/out_data packed output beat; count = beats buffered.
module split_struct_packer
    import split_struct_pkg::*;
#(
    parameter int unsigned FIELD_W    = 2,
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0]   in_fields,
    input  logic                            in_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned DATA_W = NUM_FIELDS * FIELD_W;

    logic [DATA_W-1:0] packed_beat;

    // Field ordering applied at the push; only the packed beat is stored.
    always_comb begin
        packed_beat = in_fields;
        if (in_mode == MODE_REVERSED) begin
            packed_beat = DATA_W'(reverse_fields(MAX_BITS'(in_fields), NUM_FIELDS, FIELD_W));
        end
    end

    split_struct_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (packed_beat),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (out_data),
        .count      (count)
    );

endmodule

// File: tb/tb_split_struct_packer.sv
// Scoreboard bench for split_struct_packer: the driver queues expected beats at each
// accepted push, a negedge monitor pops and compares on every output handshake.
module tb_split_struct_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [3:0] in_fields, out_data;
    logic [2:0] count;

    logic        in_valid2, in_ready2, in_mode2, out_valid2, out_ready2;
    logic [11:0] in_fields2, out_data2;
    logic [2:0]  count2;

    typedef struct {
        logic [3:0] data;
        int         push_edge;
        bit         chk_lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_struct_packer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fields(in_fields), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    split_struct_packer #(.FIELD_W(3), .NUM_FIELDS(4), .DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_fields(in_fields2), .in_mode(in_mode2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2), .count(count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bench model of the 2x2 reversal: {a,b} -> {b,a}.
    function automatic logic [3:0] rev2(input logic [3:0] f);
        return {f[1:0], f[3:2]};
    endfunction

    // Present one beat until accepted; expected value is queued at the accepting edge.
    task automatic push_beat(input logic [3:0] f, input logic m, input logic [3:0] exp, input bit lat);
        bit ok;
        exp_t e;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_fields = f;
        in_mode   = m;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("push_timeout", 32'(0), 32'(1));
        end else begin
            e.data = exp; e.push_edge = cyc + 1; e.chk_lat = lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 32'(1));
        @(posedge clk); #1;
    endtask

    // Monitor: compare each popped beat against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                if (e.chk_lat) check("latency", 32'(cyc + 1 - e.push_edge), 32'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_fields = '0; in_mode = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_fields2 = '0; in_mode2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count",     32'(count),     32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'(1));

        // Mode check: a=10, b=01.
        out_ready = 1'b1;
        push_beat(4'b1001, 1'b0, 4'b1001, 1'b1);
        push_beat(4'b1001, 1'b1, 4'b0110, 1'b1);
        wait_drain();

        // Full sweep, both modes, back to back.
        for (int m = 0; m < 2; m++) begin
            for (int f = 0; f < 16; f++) begin
                push_beat(4'(f), 1'(m), (m == 1) ? rev2(4'(f)) : 4'(f), 1'b1);
            end
        end
        wait_drain();

        // Fill and drain.
        out_ready = 1'b0;
        push_beat(4'h1, 1'b0, 4'h1, 1'b0);
        push_beat(4'h2, 1'b1, 4'h8, 1'b0);
        push_beat(4'h3, 1'b0, 4'h3, 1'b0);
        push_beat(4'hE, 1'b1, 4'hB, 1'b0);
        @(negedge clk);
        check("full_count",    32'(count),    32'(4));
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("hold_out_data", 32'(out_data), 32'(4'h1));
        in_valid = 1'b1; in_fields = 4'h5; in_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("fifth_blocked", 32'(in_ready), 32'(0));
        check("fifth_count",   32'(count),    32'(4));
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("drained_count", 32'(count), 32'(0));

        // Simultaneous push/pop at count=2 across pointer wrap.
        out_ready = 1'b0;
        push_beat(4'h7, 1'b0, 4'h7, 1'b0);
        push_beat(4'h4, 1'b1, 4'h1, 1'b0);
        check("pp_count_start", 32'(count), 32'(2));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_beat(4'(i + 3), 1'(i % 2), (i % 2 == 1) ? rev2(4'(i + 3)) : 4'(i + 3), 1'b0);
            check("pp_count", 32'(count), 32'(2));
        end
        wait_drain();

        // Reset mid-operation with three beats buffered.
        out_ready = 1'b0;
        push_beat(4'h9, 1'b0, 4'h9, 1'b0);
        push_beat(4'hA, 1'b0, 4'hA, 1'b0);
        push_beat(4'hB, 1'b0, 4'hB, 1'b0);
        @(negedge clk);
        check("pre_rst_count", 32'(count), 32'(3));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count",     32'(count),     32'(0));
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_in_ready",  32'(in_ready),  32'(0));
        check("mid_rst_out_data",  32'(out_data),  32'(0));
        q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_rst", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        push_beat(4'hC, 1'b1, 4'h3, 1'b1);
        wait_drain();

        // Wider configuration: 4 fields of 3 bits, reversed then natural.
        in_valid2 = 1'b1; in_mode2 = 1'b1; in_fields2 = {3'd7, 3'd5, 3'd2, 3'd0};
        @(negedge clk);
        check("w_in_ready", 32'(in_ready2), 32'(1));
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("w_out_valid", 32'(out_valid2), 32'(1));
        check("w_rev_data",  32'(out_data2),  32'({3'd0, 3'd2, 3'd5, 3'd7}));
        @(posedge clk); #1;
        in_valid2 = 1'b1; in_mode2 = 1'b0; in_fields2 = {3'd1, 3'd3, 3'd4, 3'd6};
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("w_nat_data", 32'(out_data2), 32'({3'd1, 3'd3, 3'd4, 3'd6}));
        @(posedge clk); #1;
        @(negedge clk);
        check("w_empty", 32'(count2), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
